// File: rtl/cpu_defs.sv
// Shared CPU definitions: fetch address map, exception codes and the
// encodings of the fetch-stage ERET sequencing FSM.
package cpu_defs;

    localparam logic [31:0] RESET_PC   = 32'h0000_3000;
    localparam logic [31:0] HANDLER_PC = 32'h0000_4180;
    localparam logic [31:0] IM_BASE    = 32'h0000_3000;
    localparam logic [31:0] IM_TOP     = 32'h0000_4FFF;

    localparam logic [4:0]  EXC_ADEL   = 5'd4;
    localparam logic [4:0]  EXC_NONE   = 5'd0;

    typedef enum logic [0:0] {
        ST_RUN       = 1'b0,
        ST_ERET_WAIT = 1'b1
    } fetch_state_t;

endpackage

// File: rtl/fetch_addr_check.sv
// Combinational fetch-address decode: AdEL detection and the IM word index
// derived from the current fetch PC.
module fetch_addr_check #(
    parameter logic [31:0] IM_BASE = cpu_defs::IM_BASE,
    parameter logic [31:0] IM_TOP  = cpu_defs::IM_TOP
) (
    input  logic [31:0] pc_f,
    output logic        adel_f,
    output logic [4:0]  excode_f,
    output logic [11:0] im_addr
);

    import cpu_defs::*;

    logic misaligned;
    logic out_of_range;

    assign misaligned   = (pc_f[1:0] != 2'b00);
    // Unsigned 32-bit compares, so addresses near 0 or near 2^32 are both caught.
    assign out_of_range = (pc_f < IM_BASE) || (pc_f > IM_TOP);

    assign adel_f   = misaligned || out_of_range;
    assign excode_f = adel_f ? EXC_ADEL : EXC_NONE;

    // The index is produced even for bad addresses; the IM data is then ignored.
    assign im_addr  = 12'((pc_f - IM_BASE) >> 2);

endmodule

// File: rtl/fetch_pc_unit.sv
// Fetch-stage PC owner: selects the next PC (exception, ERET return, redirect,
// sequential) and holds fetch off in ERET_WAIT until the ERET commits in M.
module fetch_pc_unit #(
    parameter logic [31:0] RESET_PC   = cpu_defs::RESET_PC,
    parameter logic [31:0] HANDLER_PC = cpu_defs::HANDLER_PC,
    parameter logic [31:0] IM_BASE    = cpu_defs::IM_BASE,
    parameter logic [31:0] IM_TOP     = cpu_defs::IM_TOP
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        redirect_d,
    input  logic [31:0] target_d,
    input  logic        jump_d,
    input  logic        eret_d,
    input  logic        eret_m,
    input  logic [31:0] epc,
    input  logic        exc_req,
    output logic [31:0] pc_f,
    output logic [11:0] im_addr,
    output logic        instr_valid,
    output logic        adel_f,
    output logic [4:0]  excode_f,
    output logic        bd_f
);

    import cpu_defs::*;

    fetch_state_t state;
    fetch_state_t state_next;
    logic [31:0]  pc_next;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values of its neighbours.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= ST_RUN;
            pc_f  <= RESET_PC;
        end else begin
            state <= state_next;
            pc_f  <= pc_next;
        end
    end

    // NOTE: both outputs get a default before any branch so no latch is inferred.
    always_comb begin
        state_next = state;
        pc_next    = pc_f + 32'd4;
        if (exc_req) begin
            // Exception entry also drops an ERET still waiting to commit.
            pc_next    = HANDLER_PC;
            state_next = ST_RUN;
        end else if (state == ST_ERET_WAIT) begin
            if (eret_m) begin
                pc_next    = epc;
                state_next = ST_RUN;
            end else begin
                pc_next    = pc_f;
            end
        end else if (stall) begin
            pc_next = pc_f;
        end else if (eret_d) begin
            pc_next    = pc_f;
            state_next = ST_ERET_WAIT;
        end else if (redirect_d) begin
            pc_next = target_d;
        end
    end

    always_comb begin
        instr_valid = (state == ST_RUN) && !adel_f;
        bd_f        = jump_d;
    end

    fetch_addr_check #(
        .IM_BASE (IM_BASE),
        .IM_TOP  (IM_TOP)
    ) u_addr_check (
        .pc_f     (pc_f),
        .adel_f   (adel_f),
        .excode_f (excode_f),
        .im_addr  (im_addr)
    );

endmodule

// File: tb/tb_fetch_pc_unit.sv
// Directed-vector bench for fetch_pc_unit: the driver queues the expected
// fetch-stage outputs for each cycle and a negedge monitor compares them.
module tb_fetch_pc_unit;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        stall = 1'b0;
    logic        redirect_d = 1'b0;
    logic [31:0] target_d = '0;
    logic        jump_d = 1'b0;
    logic        eret_d = 1'b0;
    logic        eret_m = 1'b0;
    logic [31:0] epc = '0;
    logic        exc_req = 1'b0;
    logic [31:0] pc_f;
    logic [11:0] im_addr;
    logic        instr_valid;
    logic        adel_f;
    logic [4:0]  excode_f;
    logic        bd_f;

    typedef struct {
        string       name;
        logic [31:0] pc;
        logic        valid;
        logic        adel;
        logic [4:0]  excode;
        logic [11:0] im;
        logic        bd;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    always #5 clk = ~clk;

    fetch_pc_unit dut (
        .clk         (clk),
        .reset       (reset),
        .stall       (stall),
        .redirect_d  (redirect_d),
        .target_d    (target_d),
        .jump_d      (jump_d),
        .eret_d      (eret_d),
        .eret_m      (eret_m),
        .epc         (epc),
        .exc_req     (exc_req),
        .pc_f        (pc_f),
        .im_addr     (im_addr),
        .instr_valid (instr_valid),
        .adel_f      (adel_f),
        .excode_f    (excode_f),
        .bd_f        (bd_f)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: compares the DUT outputs against the oldest queued expectation.
    always @(negedge clk) begin
        if (sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            check({e.name, ".pc_f"},        pc_f,                 e.pc);
            check({e.name, ".instr_valid"}, 32'(instr_valid),     32'(e.valid));
            check({e.name, ".adel_f"},      32'(adel_f),          32'(e.adel));
            check({e.name, ".excode_f"},    32'(excode_f),        32'(e.excode));
            check({e.name, ".im_addr"},     32'(im_addr),         32'(e.im));
            check({e.name, ".bd_f"},        32'(bd_f),            32'(e.bd));
        end
    end

    // Drives one cycle of inputs just after the rising edge and queues the
    // outputs expected for that cycle.
    task automatic step(input string name, input logic rs,
                        input logic st, input logic rd, input logic [31:0] tgt,
                        input logic jp, input logic ed, input logic em,
                        input logic [31:0] ep, input logic ex,
                        input logic [31:0] e_pc, input logic e_v,
                        input logic e_adel, input logic [11:0] e_im);
        exp_t e;
        @(posedge clk);
        #1;
        reset      = rs;
        stall      = st;
        redirect_d = rd;
        target_d   = tgt;
        jump_d     = jp;
        eret_d     = ed;
        eret_m     = em;
        epc        = ep;
        exc_req    = ex;
        e.name   = name;
        e.pc     = e_pc;
        e.valid  = e_v;
        e.adel   = e_adel;
        e.excode = e_adel ? 5'd4 : 5'd0;
        e.im     = e_im;
        e.bd     = jp;
        sb.push_back(e);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached with %0d pending", sb.size());
        $fatal(1, "watchdog expired");
    end

    initial begin
        //    name          rs st rd target        jp ed em epc           ex  exp_pc        v  adel im
        step("reset",       0, 0, 0, 32'h0,        0, 0, 0, 32'h0,        0,  32'h0000_3000, 1, 0, 12'h000);
        @(negedge clk); #1 reset = 1'b1;
        step("seq1",        1, 0, 0, 32'h0,        0, 0, 0, 32'h0,        0,  32'h0000_3004, 1, 0, 12'h001);
        step("seq2",        1, 0, 0, 32'h0,        0, 0, 0, 32'h0,        0,  32'h0000_3008, 1, 0, 12'h002);
        step("redir_bd",    1, 0, 1, 32'h3100,     1, 0, 0, 32'h0,        0,  32'h0000_300C, 1, 0, 12'h003);
        step("redir_land",  1, 0, 1, 32'h3010,     0, 0, 0, 32'h0,        0,  32'h0000_3100, 1, 0, 12'h040);
        step("eret_d",      1, 0, 0, 32'h0,        0, 1, 0, 32'h0,        0,  32'h0000_3010, 1, 0, 12'h004);
        step("eret_wait1",  1, 0, 1, 32'h3500,     0, 0, 0, 32'h0,        0,  32'h0000_3010, 0, 0, 12'h004);
        step("eret_wait2",  1, 0, 0, 32'h0,        0, 0, 1, 32'h3040,     0,  32'h0000_3010, 0, 0, 12'h004);
        step("eret_ret",    1, 1, 0, 32'h0,        0, 1, 0, 32'h0,        0,  32'h0000_3040, 1, 0, 12'h010);
        step("stall_hold",  1, 0, 0, 32'h0,        0, 0, 0, 32'h0,        0,  32'h0000_3040, 1, 0, 12'h010);
        step("exc_req",     1, 1, 1, 32'h3200,     0, 0, 0, 32'h0,        1,  32'h0000_3044, 1, 0, 12'h011);
        step("handler",     1, 0, 0, 32'h0,        0, 1, 0, 32'h0,        0,  32'h0000_4180, 1, 0, 12'h460);
        step("exc_in_wait", 1, 0, 0, 32'h0,        0, 0, 0, 32'h0,        1,  32'h0000_4180, 0, 0, 12'h460);
        step("exc_squash",  1, 0, 1, 32'h3002,     0, 0, 0, 32'h0,        0,  32'h0000_4180, 1, 0, 12'h460);
        step("misalign",    1, 0, 1, 32'h5000,     0, 0, 0, 32'h0,        0,  32'h0000_3002, 0, 1, 12'h000);
        step("above_top",   1, 0, 1, 32'h4FFC,     0, 0, 0, 32'h0,        0,  32'h0000_5000, 0, 1, 12'h800);
        step("last_word",   1, 0, 0, 32'h0,        0, 0, 0, 32'h0,        0,  32'h0000_4FFC, 1, 0, 12'h7FF);
        step("seq_past_top",1, 0, 1, 32'h2FFC,     0, 0, 0, 32'h0,        0,  32'h0000_5000, 0, 1, 12'h800);
        step("below_base",  1, 0, 1, 32'hFFFF_FFFC,0, 0, 0, 32'h0,        0,  32'h0000_2FFC, 0, 1, 12'hFFF);
        step("max_addr",    1, 0, 0, 32'h0,        0, 0, 0, 32'h0,        0,  32'hFFFF_FFFC, 0, 1, 12'h3FF);
        step("wrap_zero",   1, 0, 1, 32'h3010,     0, 0, 0, 32'h0,        0,  32'h0000_0000, 0, 1, 12'h400);
        step("eret_d2",     1, 0, 0, 32'h0,        0, 1, 0, 32'h0,        0,  32'h0000_3010, 1, 0, 12'h004);
        step("eret_wait3",  1, 0, 0, 32'h0,        0, 0, 0, 32'h0,        0,  32'h0000_3010, 0, 0, 12'h004);
        step("reset_wait",  0, 0, 0, 32'h0,        0, 0, 0, 32'h0,        0,  32'h0000_3000, 1, 0, 12'h000);
        @(negedge clk); #1 reset = 1'b1;
        step("post_reset",  1, 0, 0, 32'h0,        0, 0, 1, 32'h3040,     0,  32'h0000_3004, 1, 0, 12'h001);
        step("post_reset2", 1, 0, 0, 32'h0,        0, 0, 0, 32'h0,        0,  32'h0000_3008, 1, 0, 12'h002);

        for (int i = 0; i < 5 && sb.size() > 0; i++) @(posedge clk);
        if (sb.size() > 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL drain: %0d expectations left unchecked, required 0", sb.size());
        end
        @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
